// File: rtl/vic_pkg.sv
// Shared constants, FSM state encoding and the optional boot-default table for the
// vic_registers access arbiter. The boot table only exists when VIC_REG_BOOT_INIT_EN is defined.
package vic_pkg;

   localparam int unsigned VIC_ADDR_W   = 5;
   localparam int unsigned VIC_DATA_W   = 4;
   localparam int unsigned VIC_NUM_REGS = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StCap  = 2'd2,
      StInit = 2'd3
   } vic_state_e;

`ifdef VIC_REG_BOOT_INIT_EN
   // Register i lives in bits [4*i+3 : 4*i].
   localparam logic [VIC_NUM_REGS*VIC_DATA_W-1:0] VIC_REG_DEFAULTS =
      128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

   function automatic logic [VIC_DATA_W-1:0] vic_reg_default(input logic [VIC_ADDR_W-1:0] idx);
      return VIC_REG_DEFAULTS[int'(idx)*VIC_DATA_W +: VIC_DATA_W];
   endfunction
`endif

endpackage

// File: rtl/vic_rr_arb2.sv
// Two-way round-robin arbiter. req_i[0] is requester A, req_i[1] is requester B.
// The priority pointer moves past the granted requester only when advance_i is high.
module vic_rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   // 0: A has priority on a tie, 1: B has priority.
   logic ptr_q, ptr_d;

   // Grant decode and pointer next-state.
   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && (!ptr_q || !req_i[1])) begin
         gnt_o = 2'b01;
      end else if (req_i[1]) begin
         gnt_o = 2'b10;
      end
      ptr_d = ptr_q;
      if (advance_i && (gnt_o != 2'b00)) begin
         ptr_d = gnt_o[0];
      end
   end

   // Pointer register, synchronous reset gives A the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vic_reg_arbiter.sv
// Shares the single vic_registers access port between requester A (host bus) and
// requester B (video/debug). One access at a time: IDLE -> ACC -> CAP -> IDLE, all outputs
// registered. Optional VIC_REG_BOOT_INIT_EN: after reset an INIT pass writes the default
// table to all 32 registers before any request is granted.
module vic_reg_arbiter
   import vic_pkg::*;
#(
   parameter int unsigned ADDR_W = VIC_ADDR_W,
   parameter int unsigned DATA_W = VIC_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_a_req,
   input  logic              i_a_wr,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic              o_a_ack,
   output logic [DATA_W-1:0] o_a_rdata,
   input  logic              i_b_req,
   input  logic              i_b_wr,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic              o_b_ack,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic [ADDR_W-1:0] o_VIC_regaddr,
   output logic [DATA_W-1:0] o_VIC_data,
   output logic              o_VIC_we,
   output logic              o_VIC_re,
   input  logic [DATA_W-1:0] i_VIC_data,
   output logic              o_busy
);

   vic_state_e        state_q, state_d;
   logic              gid_q, gid_d;          // 0: A granted, 1: B granted
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] op_addr_q, op_addr_d;
   logic [DATA_W-1:0] op_wdata_q, op_wdata_d;

   logic [ADDR_W-1:0] regaddr_q, regaddr_d;
   logic [DATA_W-1:0] vdata_q, vdata_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              busy_q, busy_d;

`ifdef VIC_REG_BOOT_INIT_EN
   logic [VIC_ADDR_W-1:0] cnt_q, cnt_d;
`endif

   logic [1:0] gnt;
   logic       advance;

   vic_rr_arb2 u_arb (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .req_i     ({i_b_req, i_a_req}),
      .advance_i (advance),
      .gnt_o     (gnt)
   );

   // Next-state and registered-output computation for the access sequencer.
   always_comb begin
      state_d    = state_q;
      gid_d      = gid_q;
      wr_d       = wr_q;
      op_addr_d  = op_addr_q;
      op_wdata_d = op_wdata_q;
      advance    = 1'b0;
      regaddr_d  = '0;
      vdata_d    = '0;
      we_d       = 1'b0;
      re_d       = 1'b0;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
`ifdef VIC_REG_BOOT_INIT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (gnt != 2'b00) begin
               // Operands are latched here so a later req drop cannot cancel the access.
               advance = 1'b1;
               gid_d   = gnt[1];
               if (gnt[1]) begin
                  wr_d       = i_b_wr;
                  op_addr_d  = i_b_addr;
                  op_wdata_d = i_b_wdata;
               end else begin
                  wr_d       = i_a_wr;
                  op_addr_d  = i_a_addr;
                  op_wdata_d = i_a_wdata;
               end
               state_d = StAcc;
            end
         end
         StAcc: begin
            regaddr_d = op_addr_q;
            if (wr_q) begin
               vdata_d = op_wdata_q;
               we_d    = 1'b1;
            end else begin
               re_d = 1'b1;
            end
            state_d = StCap;
         end
         StCap: begin
            if (!wr_q) begin
               if (gid_q) begin
                  b_rdata_d = i_VIC_data;
               end else begin
                  a_rdata_d = i_VIC_data;
               end
            end
            a_ack_d = !gid_q;
            b_ack_d = gid_q;
            state_d = StIdle;
         end
         StInit: begin
`ifdef VIC_REG_BOOT_INIT_EN
            regaddr_d = ADDR_W'(cnt_q);
            vdata_d   = DATA_W'(vic_reg_default(cnt_q));
            we_d      = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == VIC_ADDR_W'(VIC_NUM_REGS - 1)) begin
               state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
         end
      endcase
      busy_d = (state_d != StIdle);
`ifdef VIC_REG_BOOT_INIT_EN
      // Keep busy up through the cycle that carries the final default write.
      busy_d = busy_d || (state_q == StInit);
`endif
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
`ifdef VIC_REG_BOOT_INIT_EN
         state_q <= StInit;
         busy_q  <= 1'b1;
         cnt_q   <= '0;
`else
         state_q <= StIdle;
         busy_q  <= 1'b0;
`endif
         gid_q      <= 1'b0;
         wr_q       <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         regaddr_q  <= '0;
         vdata_q    <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
`ifdef VIC_REG_BOOT_INIT_EN
         cnt_q      <= cnt_d;
`endif
         gid_q      <= gid_d;
         wr_q       <= wr_d;
         op_addr_q  <= op_addr_d;
         op_wdata_q <= op_wdata_d;
         regaddr_q  <= regaddr_d;
         vdata_q    <= vdata_d;
         we_q       <= we_d;
         re_q       <= re_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign o_a_ack       = a_ack_q;
   assign o_a_rdata     = a_rdata_q;
   assign o_b_ack       = b_ack_q;
   assign o_b_rdata     = b_rdata_q;
   assign o_VIC_regaddr = regaddr_q;
   assign o_VIC_data    = vdata_q;
   assign o_VIC_we      = we_q;
   assign o_VIC_re      = re_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_vic_reg_arbiter.sv
// Bench for vic_reg_arbiter: directed steps followed by random rounds, checked against a
// transaction-level model (register array, last-served pointer, per-requester read data).
module tb_vic_reg_arbiter;
   import vic_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_a_req = 1'b0, i_a_wr = 1'b0;
   logic [4:0] i_a_addr = '0;
   logic [3:0] i_a_wdata = '0;
   logic       i_b_req = 1'b0, i_b_wr = 1'b0;
   logic [4:0] i_b_addr = '0;
   logic [3:0] i_b_wdata = '0;
   logic       o_a_ack, o_b_ack, o_VIC_we, o_VIC_re, o_busy;
   logic [3:0] o_a_rdata, o_b_rdata, o_VIC_data, vic_rdata;
   logic [4:0] o_VIC_regaddr;

   // Stand-in for vic_registers: 32x4 buffer, synchronous write, combinational read.
   logic [127:0] vmem = '0;

   int         total = 0;
   int         bad = 0;
   logic [3:0] ref_mem [32];
   logic [3:0] exp_rd [2];
   int         ptr = 0;   // requester that wins the next tie

   always #5 i_clk = ~i_clk;

   vic_reg_arbiter dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_a_req       (i_a_req),
      .i_a_wr        (i_a_wr),
      .i_a_addr      (i_a_addr),
      .i_a_wdata     (i_a_wdata),
      .o_a_ack       (o_a_ack),
      .o_a_rdata     (o_a_rdata),
      .i_b_req       (i_b_req),
      .i_b_wr        (i_b_wr),
      .i_b_addr      (i_b_addr),
      .i_b_wdata     (i_b_wdata),
      .o_b_ack       (o_b_ack),
      .o_b_rdata     (o_b_rdata),
      .o_VIC_regaddr (o_VIC_regaddr),
      .o_VIC_data    (o_VIC_data),
      .o_VIC_we      (o_VIC_we),
      .o_VIC_re      (o_VIC_re),
      .i_VIC_data    (vic_rdata),
      .o_busy        (o_busy)
   );

   always @(posedge i_clk) begin
      if (o_VIC_we) vmem[{o_VIC_regaddr, 2'b00} +: 4] <= o_VIC_data;
   end
   assign vic_rdata = vmem[{o_VIC_regaddr, 2'b00} +: 4];

   function automatic logic [127:0] ref_vec();
      logic [127:0] v;
      for (int i = 0; i < 32; i++) v[i*4 +: 4] = ref_mem[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // After reset release: with boot init, wait out the INIT pass and adopt the defaults.
   task automatic finish_reset();
`ifdef VIC_REG_BOOT_INIT_EN
      logic [127:0] dv;
      int c;
      dv = VIC_REG_DEFAULTS;
      c  = 0;
      while (o_busy && c < 50) begin
         tick();
         c++;
      end
      check("init_end_busy", o_busy, 0);
      for (int i = 0; i < 32; i++) ref_mem[i] = dv[i*4 +: 4];
`endif
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
      ptr = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      finish_reset();
   endtask

   // One arbitration round: enabled requesters hold req until their own ack.
   task automatic round(input bit a_en, input bit b_en,
                        input logic a_wr, input logic [4:0] a_ad, input logic [3:0] a_wd,
                        input logic b_wr, input logic [4:0] b_ad, input logic [3:0] b_wd);
      logic       wr [2];
      logic [4:0] ad [2];
      logic [3:0] wd [2];
      int         order [2];
      int         n, idx, cyc, cur, got;
      bit         pulse;
      wr[0] = a_wr; ad[0] = a_ad; wd[0] = a_wd;
      wr[1] = b_wr; ad[1] = b_ad; wd[1] = b_wd;
      n = int'(a_en) + int'(b_en);
      if (n == 2) begin
         order[0] = ptr;
         order[1] = 1 - ptr;
      end else begin
         order[0] = a_en ? 0 : 1;
         order[1] = order[0];
      end
      i_a_req = a_en; i_a_wr = a_wr; i_a_addr = a_ad; i_a_wdata = a_wd;
      i_b_req = b_en; i_b_wr = b_wr; i_b_addr = b_ad; i_b_wdata = b_wd;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 30) begin
         tick();
         cyc++;
         cur   = order[idx];
         pulse = (cyc == 3 * idx + 2);
         check("vic_we", o_VIC_we, pulse && wr[cur]);
         check("vic_re", o_VIC_re, pulse && !wr[cur]);
         if (pulse) check("vic_addr", o_VIC_regaddr, ad[cur]);
         if (pulse && wr[cur]) check("vic_wdata", o_VIC_data, wd[cur]);
         check("dual_ack", o_a_ack & o_b_ack, 0);
         if (o_a_ack || o_b_ack) begin
            got = o_b_ack ? 1 : 0;
            check("ack_id", got, cur);
            check("ack_cycle", cyc, 3 * idx + 3);
            if (wr[cur]) ref_mem[ad[cur]] = wd[cur];
            else exp_rd[cur] = ref_mem[ad[cur]];
            check("rdata", (cur == 0) ? o_a_rdata : o_b_rdata, exp_rd[cur]);
            if (got == 0) i_a_req = 1'b0;
            else i_b_req = 1'b0;
            ptr = 1 - cur;
            idx++;
         end
      end
      if (idx < n) check("round_timeout", idx, n);
      i_a_req = 1'b0;
      i_b_req = 1'b0;
      tick();
   endtask

   initial begin
      int cyc, cnt, got, pulses;
      logic [127:0] dv;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;

`ifdef VIC_REG_BOOT_INIT_EN
      // Boot init with A holding a read of register 3 the whole time.
      dv = VIC_REG_DEFAULTS;
      i_a_req = 1'b1; i_a_wr = 1'b0; i_a_addr = 5'd3;
      tick();
      tick();
      check("rst_we", o_VIC_we, 0);
      check("rst_ack", o_a_ack, 0);
      check("rst_busy_init", o_busy, 1);
      i_rst = 1'b0;
      pulses = 0;
      cyc = 0;
      while (pulses < 32 && cyc < 60) begin
         tick();
         cyc++;
         check("init_busy", o_busy, 1);
         check("init_no_ack", o_a_ack, 0);
         if (o_VIC_we) begin
            check("init_addr", o_VIC_regaddr, pulses);
            check("init_data", o_VIC_data, dv[pulses*4 +: 4]);
            pulses++;
         end
      end
      if (pulses < 32) check("init_pulses", pulses, 32);
      cyc = 0;
      while (!o_a_ack && cyc < 10) begin
         tick();
         cyc++;
      end
      check("init_ack_cycle", cyc, 3);
      check("init_rdata", o_a_rdata, dv[12 +: 4]);
      i_a_req = 1'b0;
      exp_rd[0] = dv[12 +: 4];
      ptr = 1;
      tick();
      check("init_buffer", vmem, dv);
      for (int i = 0; i < 32; i++) ref_mem[i] = dv[i*4 +: 4];
`else
      tick();
      tick();
      check("rst_we", o_VIC_we, 0);
      check("rst_re", o_VIC_re, 0);
      check("rst_addr", o_VIC_regaddr, 0);
      check("rst_data", o_VIC_data, 0);
      check("rst_acks", {o_a_ack, o_b_ack}, 0);
      check("rst_rdata", {o_a_rdata, o_b_rdata}, 0);
      check("rst_busy", o_busy, 0);
      i_rst = 1'b0;
      tick();
`endif

      // A writes 5 <- 0xA, then reads it back.
      round(1, 0, 1'b1, 5'd5, 4'hA, 1'b0, 5'd0, 4'h0);
      check("buf_addr5", vmem[23:20], 4'hA);
      round(1, 0, 1'b0, 5'd5, 4'h0, 1'b0, 5'd0, 4'h0);
      check("b_rdata_untouched", o_b_rdata, exp_rd[1]);

      // Simultaneous A and B writes from a fresh pointer: A first, B three cycles later.
      do_reset();
      round(1, 1, 1'b1, 5'd1, 4'h3, 1'b1, 5'd2, 4'hC);

      // Both reading continuously: grants alternate A,B,A,B,A,B.
      do_reset();
      i_a_req = 1'b1; i_a_wr = 1'b0; i_a_addr = 5'd1;
      i_b_req = 1'b1; i_b_wr = 1'b0; i_b_addr = 5'd2;
      cyc = 0;
      cnt = 0;
      while (cnt < 6 && cyc < 40) begin
         tick();
         cyc++;
         check("rr_dual_ack", o_a_ack & o_b_ack, 0);
         if (o_a_ack || o_b_ack) begin
            got = o_b_ack ? 1 : 0;
            check("rr_order", got, ptr);
            check("rr_cycle", cyc, 3 * (cnt + 1));
            exp_rd[ptr] = ref_mem[(ptr == 0) ? 1 : 2];
            check("rr_rdata", (ptr == 0) ? o_a_rdata : o_b_rdata, exp_rd[ptr]);
            ptr = 1 - ptr;
            cnt++;
            if (cnt == 6) begin
               i_a_req = 1'b0;
               i_b_req = 1'b0;
            end
         end
      end
      if (cnt < 6) check("rr_timeout", cnt, 6);
      i_a_req = 1'b0;
      i_b_req = 1'b0;
      tick();
      tick();

      // Reset during ACC: no write, no ack, everything idle; then a retry succeeds.
      i_a_req = 1'b1; i_a_wr = 1'b1; i_a_addr = 5'd7; i_a_wdata = ~ref_mem[7];
      tick();
      i_rst = 1'b1;
      i_a_req = 1'b0;
      tick();
      check("midrst_we", o_VIC_we, 0);
      check("midrst_re", o_VIC_re, 0);
      check("midrst_addr", o_VIC_regaddr, 0);
      check("midrst_ack", {o_a_ack, o_b_ack}, 0);
      check("midrst_rdata", {o_a_rdata, o_b_rdata}, 0);
`ifdef VIC_REG_BOOT_INIT_EN
      check("midrst_busy", o_busy, 1);
`else
      check("midrst_busy", o_busy, 0);
`endif
      i_rst = 1'b0;
      ptr = 0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_no_ack", o_a_ack, 0);
      end
`ifndef VIC_REG_BOOT_INIT_EN
      check("midrst_no_write", vmem[31:28], ref_mem[7]);
`endif
      finish_reset();
      round(1, 0, 1'b1, 5'd7, 4'h5, 1'b0, 5'd0, 4'h0);
      check("retry_write", vmem[31:28], 4'h5);

      // Random rounds against the model.
      for (int r = 0; r < 30; r++) begin
         bit ae, be;
         ae = 1'($urandom_range(0, 1));
         be = ae ? 1'($urandom_range(0, 1)) : 1'b1;
         round(ae, be,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      end
      check("final_buffer", vmem, ref_vec());
      check("final_idle", o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
